// File: rtl/nios2_jtag_ocimem_seq_if.sv
// ---------------------------------------------------------------------------
// nios2_jtag_ocimem_seq_if
// CPU-side Avalon-MM slave bundle for the OCI debug RAM sequencer.
//   address     word address into the debug RAM
//   chipselect  slave select
//   read/write  transfer request (never both at once)
//   writedata   write data, byte lanes qualified by byteenable
//   debugaccess write permission; writes without it are acknowledged but dropped
//   readdata    read data, valid in the cycle waitrequest is low for a read
//   waitrequest combinational stall back to the master
// ---------------------------------------------------------------------------
interface nios2_jtag_ocimem_seq_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, chipselect, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );
endinterface

// File: rtl/nios2_jtag_ocimem_seq.sv
// ---------------------------------------------------------------------------
// nios2_jtag_ocimem_seq
// Sequences JTAG-initiated reads/writes into the on-chip debug RAM and shares
// the same RAM with a CPU Avalon-MM slave port. JTAG always wins arbitration.
//   clk, reset               system clock, synchronous active-high reset
//   jdo                      JTAG data word (address in [ADDR_W+2:3], data in
//                            [34:3], read flag [34], error-clear flag [35])
//   take_action_ocimem_a     load address, optionally read
//   take_no_action_ocimem_a  read at next address
//   take_action_ocimem_b     write data word at current address, post-increment
//   cpu                      Avalon-MM slave (see nios2_jtag_ocimem_seq_if)
//   MonDReg                  JTAG read data
//   monitor_ready            last JTAG command finished
//   monitor_error            sticky: a JTAG command hit a busy sequencer
// ---------------------------------------------------------------------------
module nios2_jtag_ocimem_seq #(
  parameter int ADDR_W = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [37:0]                    jdo,
  input  logic                           take_action_ocimem_a,
  input  logic                           take_no_action_ocimem_a,
  input  logic                           take_action_ocimem_b,
  nios2_jtag_ocimem_seq_if.slave         cpu,
  output logic [31:0]                    MonDReg,
  output logic                           monitor_ready,
  output logic                           monitor_error
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_RDCAP = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mon_areg;
  logic              cpu_rd_pending;

  logic              any_strobe;
  logic              idle;
  logic              jtag_wr_sel;
  logic              jtag_wr;
  logic              cpu_req;
  logic              cpu_is_wr;
  logic              cpu_is_rd;
  logic              cpu_rd_issue;
  logic              cpu_wr_ok;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       wr_data;
  logic [3:0]        lane_we;
  logic [31:0]       rd_q;
  logic              unused_jdo;

  assign unused_jdo  = ^{jdo[37:36], jdo[2:0]};

  assign any_strobe  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign idle        = (state == ST_IDLE);

  // JTAG write path; the RAM write itself is suppressed while reset is high
  assign jtag_wr_sel = idle & take_action_ocimem_b;
  assign jtag_wr     = jtag_wr_sel & ~reset;

  // A simultaneous read+write request is treated as a write
  assign cpu_req     = cpu.chipselect & (cpu.read | cpu.write);
  assign cpu_is_wr   = cpu.chipselect & cpu.write;
  assign cpu_is_rd   = cpu.chipselect & cpu.read & ~cpu.write;

  assign cpu.waitrequest = cpu_req & (~idle | any_strobe | (cpu_is_rd & ~cpu_rd_pending));

  // First eligible read cycle: present the address, data is back next cycle
  assign cpu_rd_issue = cpu_is_rd & idle & ~any_strobe & ~cpu_rd_pending;
  assign cpu_wr_ok    = cpu_is_wr & idle & ~any_strobe & cpu.debugaccess & ~reset;

  // Single RAM port: the sequencer owns it in RD and on a JTAG write,
  // otherwise the CPU address drives it.
  assign ram_addr = ((state == ST_RD) || jtag_wr_sel) ? mon_areg : cpu.address;
  assign wr_data  = jtag_wr_sel ? jdo[34:3] : cpu.writedata;
  assign lane_we  = {4{jtag_wr}} | ({4{cpu_wr_ok}} & cpu.byteenable);

  // Byte-wide lanes give byte-write capability with a registered read
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        mem[ram_addr] <= wr_data[8*gi +: 8];
      end
      lane_q <= mem[ram_addr];
    end

    assign rd_q[8*gi +: 8] = lane_q;
  end

  // rd_q is shared with the JTAG read path, so only expose it to the CPU in
  // the cycle its read completes; this also makes readdata 0 out of reset.
  assign cpu.readdata = cpu_rd_pending ? rd_q : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      mon_areg       <= '0;
      MonDReg        <= 32'h0;
      monitor_ready  <= 1'b0;
      monitor_error  <= 1'b0;
      cpu_rd_pending <= 1'b0;
    end else begin
      // A JTAG strobe in the pending cycle blocks issue and so drops the read
      cpu_rd_pending <= cpu_rd_issue;
      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            mon_areg      <= jdo[ADDR_W+2:3];
            monitor_ready <= ~jdo[34];
            if (jdo[35]) begin
              monitor_error <= 1'b0;
            end
            if (jdo[34]) begin
              state <= ST_RD;
            end
          end else if (take_no_action_ocimem_a) begin
            mon_areg      <= mon_areg + 1'b1;
            monitor_ready <= 1'b0;
            state         <= ST_RD;
          end else if (take_action_ocimem_b) begin
            mon_areg      <= mon_areg + 1'b1;
            monitor_ready <= 1'b1;
          end
        end
        ST_RD: begin
          if (any_strobe) begin
            monitor_error <= 1'b1;
          end
          state <= ST_RDCAP;
        end
        ST_RDCAP: begin
          if (any_strobe) begin
            monitor_error <= 1'b1;
          end
          MonDReg       <= rd_q;
          monitor_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
